// File: rtl/mat_slice_lsu_if.sv
// Data-memory bus between the matrix-slice LSU (master) and data memory (slave).
interface mat_slice_lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [31:0]     dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mat_slice_lsu.sv
// Matrix-slice load/store sequencer: one data-memory beat per slice element,
// loads written to the matrix register file as a whole slice on completion.
module mat_slice_lsu #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [31:0]          base_addr_i,
  input  logic [1:0]           mat_rd_i,
  input  logic [ROWS*XLEN-1:0] st_slice_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic                 err_o,
  mat_slice_lsu_if.master      dmem,
  output logic                 mrf_we_o,
  output logic [1:0]           mrf_waddr_o,
  output logic [ROWS*XLEN-1:0] mrf_wdata_o
);

  localparam int unsigned BW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SW = ROWS * XLEN;
  localparam logic [BW-1:0] LAST = BW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q;
  logic            op_we_q;
  logic            err_q;
  logic [31:0]     base_q;
  logic [1:0]      rd_q;
  logic [SW-1:0]   st_q;
  logic [SW-1:0]   buf_q;

  logic            accept;
  logic            reject;
  logic            beat_inc;
  logic            capture;
  logic            is_last;
  logic            aligned;

  assign is_last = (beat_q == LAST);
  assign aligned = (base_addr_i[1:0] == 2'b00);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    beat_inc = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && (mem_read_i ^ mem_write_i) && aligned) begin
          accept  = 1'b1;
          state_d = REQ;
        end else if (start_i && (mem_read_i || mem_write_i)) begin
          // both directions requested or misaligned base: fail without access
          reject  = 1'b1;
          state_d = DONE;
        end
      end
      REQ: begin
        if (dmem.dmem_gnt) begin
          if (!op_we_q) begin
            state_d = WAIT_R;
          end else if (is_last) begin
            state_d = DONE;
          end else begin
            beat_inc = 1'b1;
          end
        end
      end
      WAIT_R: begin
        if (dmem.dmem_rvalid) begin
          capture = 1'b1;
          if (is_last) begin
            state_d = DONE;
          end else begin
            beat_inc = 1'b1;
            state_d  = REQ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation context latched at accept, beat counter and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q  <= '0;
      op_we_q <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      rd_q    <= '0;
      st_q    <= '0;
    end else if (accept) begin
      beat_q  <= '0;
      op_we_q <= mem_write_i;
      err_q   <= 1'b0;
      base_q  <= base_addr_i;
      rd_q    <= mat_rd_i;
      st_q    <= st_slice_i;
    end else if (reject) begin
      err_q   <= 1'b1;
    end else if (beat_inc) begin
      beat_q  <= beat_q + BW'(1);
    end
  end

  // Load slice buffer, one element per returned beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (capture) begin
      buf_q[32'(beat_q) * XLEN +: XLEN] <= dmem.dmem_rdata;
    end
  end

  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = (state_q == REQ) && op_we_q;
  assign dmem.dmem_addr  = base_q + (32'(beat_q) << 2);
  assign dmem.dmem_wdata = st_q[32'(beat_q) * XLEN +: XLEN];

  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == DONE) && err_q;
  assign mrf_we_o    = (state_q == DONE) && !err_q && !op_we_q;
  assign mrf_waddr_o = rd_q;
  assign mrf_wdata_o = buf_q;

  // Stall while sequencing, and in the cycle a memory instruction arrives
  assign stall_o = (state_q == REQ) || (state_q == WAIT_R) ||
                   ((state_q == IDLE) && start_i && (mem_read_i || mem_write_i));

endmodule

// File: tb/tb_mat_slice_lsu.sv
// Directed self-checking bench for mat_slice_lsu (ROWS=4, XLEN=32).
module tb_mat_slice_lsu;

  localparam int unsigned ROWS = 4;
  localparam int unsigned XLEN = 32;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 mem_read;
  logic                 mem_write;
  logic [31:0]          base_addr;
  logic [1:0]           mat_rd;
  logic [ROWS*XLEN-1:0] st_slice;
  logic                 stall;
  logic                 done;
  logic                 err;
  logic                 mrf_we;
  logic [1:0]           mrf_waddr;
  logic [ROWS*XLEN-1:0] mrf_wdata;

  int n_cmp;
  int n_err;
  int cyc;

  mat_slice_lsu_if #(.XLEN(XLEN)) dmem ();

  mat_slice_lsu #(.ROWS(ROWS), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .mem_read_i  (mem_read),
    .mem_write_i (mem_write),
    .base_addr_i (base_addr),
    .mat_rd_i    (mat_rd),
    .st_slice_i  (st_slice),
    .stall_o     (stall),
    .done_o      (done),
    .err_o       (err),
    .dmem        (dmem),
    .mrf_we_o    (mrf_we),
    .mrf_waddr_o (mrf_waddr),
    .mrf_wdata_o (mrf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Store with grant tied high: one beat per cycle, DONE at cycle ROWS+1
  task automatic store_seq(input logic [31:0] base, input logic [127:0] slice, input string tag);
    logic [31:0] a;
    dmem.dmem_gnt = 1'b1;
    start = 1'b1; mem_write = 1'b1; mem_read = 1'b0;
    base_addr = base; st_slice = slice; mat_rd = 2'd1;
    #1;
    check_eq({tag, "_stall_start"}, 128'(stall), 128'(1));
    cyc = 0;
    tick();
    idle_inputs();
    for (int b = 0; b < 4; b++) begin
      a = base + 32'(b * 4);
      check_eq({tag, "_req"},   128'(dmem.dmem_req),   128'(1));
      check_eq({tag, "_we"},    128'(dmem.dmem_we),    128'(1));
      check_eq({tag, "_addr"},  128'(dmem.dmem_addr),  128'(a));
      check_eq({tag, "_wdata"}, 128'(dmem.dmem_wdata), 128'(slice[b*32 +: 32]));
      check_eq({tag, "_mrfwe"}, 128'(mrf_we),          128'(0));
      tick();
    end
    check_eq({tag, "_done"},      128'(done),   128'(1));
    check_eq({tag, "_done_cyc"},  128'(cyc),    128'(5));
    check_eq({tag, "_err"},       128'(err),    128'(0));
    check_eq({tag, "_mrfwe_end"}, 128'(mrf_we), 128'(0));
    check_eq({tag, "_stall_end"}, 128'(stall),  128'(0));
    dmem.dmem_gnt = 1'b0;
    tick();
    check_eq({tag, "_idle_done"}, 128'(done), 128'(0));
  endtask

  // Load; optional grant withholding of wait_n cycles on beat wait_beat
  task automatic load_seq(input logic [31:0] base, input logic [1:0] rd, input logic [127:0] data,
                          input int wait_beat, input int wait_n, input int exp_cyc, input string tag);
    logic [31:0] a;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0;
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    base_addr = base; mat_rd = rd;
    #1;
    check_eq({tag, "_stall_start"}, 128'(stall), 128'(1));
    cyc = 0;
    tick();
    idle_inputs();
    for (int b = 0; b < 4; b++) begin
      a = base + 32'(b * 4);
      if (b == wait_beat) begin
        for (int w = 0; w < wait_n; w++) begin
          check_eq({tag, "_wait_addr"},  128'(dmem.dmem_addr), 128'(a));
          check_eq({tag, "_wait_req"},   128'(dmem.dmem_req),  128'(1));
          check_eq({tag, "_wait_stall"}, 128'(stall),          128'(1));
          tick();
        end
      end
      dmem.dmem_gnt = 1'b1;
      check_eq({tag, "_req"},  128'(dmem.dmem_req),  128'(1));
      check_eq({tag, "_we"},   128'(dmem.dmem_we),   128'(0));
      check_eq({tag, "_addr"}, 128'(dmem.dmem_addr), 128'(a));
      tick();
      dmem.dmem_gnt = 1'b0;
      check_eq({tag, "_waitr_req"},   128'(dmem.dmem_req), 128'(0));
      check_eq({tag, "_waitr_stall"}, 128'(stall),         128'(1));
      dmem.dmem_rvalid = 1'b1;
      dmem.dmem_rdata  = data[b*32 +: 32];
      tick();
      dmem.dmem_rvalid = 1'b0;
      dmem.dmem_rdata  = '0;
    end
    check_eq({tag, "_done"},      128'(done),      128'(1));
    check_eq({tag, "_done_cyc"},  128'(cyc),       128'(exp_cyc));
    check_eq({tag, "_err"},       128'(err),       128'(0));
    check_eq({tag, "_mrfwe"},     128'(mrf_we),    128'(1));
    check_eq({tag, "_mrfwaddr"},  128'(mrf_waddr), 128'(rd));
    check_eq({tag, "_mrfwdata"},  mrf_wdata,       data);
    check_eq({tag, "_stall_end"}, 128'(stall),     128'(0));
    tick();
    check_eq({tag, "_idle_mrfwe"}, 128'(mrf_we), 128'(0));
  endtask

  // Rejected request: no bus access, DONE with error the next cycle
  task automatic err_seq(input logic rd, input logic wr, input logic [31:0] base, input string tag);
    dmem.dmem_gnt = 1'b1;
    start = 1'b1; mem_read = rd; mem_write = wr; base_addr = base;
    #1;
    check_eq({tag, "_stall_start"}, 128'(stall), 128'(1));
    tick();
    idle_inputs();
    check_eq({tag, "_req"},   128'(dmem.dmem_req), 128'(0));
    check_eq({tag, "_done"},  128'(done),          128'(1));
    check_eq({tag, "_err"},   128'(err),           128'(1));
    check_eq({tag, "_mrfwe"}, 128'(mrf_we),        128'(0));
    check_eq({tag, "_stall"}, 128'(stall),         128'(0));
    tick();
    check_eq({tag, "_after_done"}, 128'(done), 128'(0));
    check_eq({tag, "_after_err"},  128'(err),  128'(0));
    dmem.dmem_gnt = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    idle_inputs();
    base_addr = '0; mat_rd = '0; st_slice = '0;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
    #12;
    check_eq("rst_stall",     128'(stall),            128'(0));
    check_eq("rst_done",      128'(done),             128'(0));
    check_eq("rst_err",       128'(err),              128'(0));
    check_eq("rst_req",       128'(dmem.dmem_req),    128'(0));
    check_eq("rst_we",        128'(dmem.dmem_we),     128'(0));
    check_eq("rst_addr",      128'(dmem.dmem_addr),   128'(0));
    check_eq("rst_wdata",     128'(dmem.dmem_wdata),  128'(0));
    check_eq("rst_mrfwe",     128'(mrf_we),           128'(0));
    check_eq("rst_mrfwaddr",  128'(mrf_waddr),        128'(0));
    check_eq("rst_mrfwdata",  mrf_wdata,              128'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // start with neither direction set is ignored
    start = 1'b1;
    #1;
    check_eq("nop_stall", 128'(stall), 128'(0));
    tick();
    check_eq("nop_req",  128'(dmem.dmem_req), 128'(0));
    check_eq("nop_done", 128'(done),          128'(0));
    idle_inputs();

    store_seq(32'h0000_0100, {32'hD, 32'hC, 32'hB, 32'hA}, "st100");
    load_seq(32'h0000_0200, 2'd2, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, 9, "ld200");
    load_seq(32'h0000_0200, 2'd3, {32'h8888, 32'h7777, 32'h6666, 32'h5555}, 1, 3, 12, "ldwait");
    err_seq(1'b1, 1'b0, 32'h0000_0102, "misal");
    err_seq(1'b1, 1'b1, 32'h0000_0100, "both");
    store_seq(32'hFFFF_FFF8, {32'h4, 32'h3, 32'h2, 32'h1}, "stwrap");

    // reset while waiting for the beat-2 read data
    start = 1'b1; mem_read = 1'b1; base_addr = 32'h0000_0300; mat_rd = 2'd1;
    dmem.dmem_gnt = 1'b1;
    tick();
    idle_inputs();
    for (int b = 0; b < 3; b++) begin
      dmem.dmem_gnt = 1'b1;
      tick();
      dmem.dmem_gnt = 1'b0;
      if (b < 2) begin
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'hA0 + 32'(b);
        tick();
        dmem.dmem_rvalid = 1'b0;
      end
    end
    check_eq("rstmid_pre_stall", 128'(stall),          128'(1));
    check_eq("rstmid_pre_req",   128'(dmem.dmem_req),  128'(0));
    check_eq("rstmid_pre_addr",  128'(dmem.dmem_addr), 128'(32'h308));
    rst = 1'b1;
    #1;
    check_eq("rstmid_stall",    128'(stall),            128'(0));
    check_eq("rstmid_req",      128'(dmem.dmem_req),    128'(0));
    check_eq("rstmid_addr",     128'(dmem.dmem_addr),   128'(0));
    check_eq("rstmid_done",     128'(done),             128'(0));
    check_eq("rstmid_mrfwe",    128'(mrf_we),           128'(0));
    check_eq("rstmid_mrfwdata", mrf_wdata,              128'(0));
    tick();
    rst = 1'b0;
    dmem.dmem_rvalid = 1'b1;
    dmem.dmem_rdata  = 32'hDEAD;
    tick();
    dmem.dmem_rvalid = 1'b0;
    check_eq("late_rv_done",    128'(done),           128'(0));
    check_eq("late_rv_mrfwe",   128'(mrf_we),         128'(0));
    check_eq("late_rv_req",     128'(dmem.dmem_req),  128'(0));
    check_eq("late_rv_mrfdata", mrf_wdata,            128'(0));
    tick();
    check_eq("late_rv_done2",   128'(done),           128'(0));
    store_seq(32'h0000_0400, {32'h14, 32'h13, 32'h12, 32'h11}, "st_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global bound on run time
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
